csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control and status register file for the in-order core; it terminates the CSR write path driven by the Writeback stage and serves combinational CSR reads to Execute. It holds trap state (mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch) and the 64-bit mcycle/minstret counters. It sequences trap entry and mret, and it raises a gated interrupt request toward the pipeline.

## Interface

- HART_ID, 0: value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0000_0100: reset value of mtvec.
- clock  in  1  core clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears or initialises all state.
- readAddress  in  12  CSR address read by Execute.
- readData  out  32  combinational value of readAddress; 0 when illegal.
- readIllegal  out  1  readAddress is not implemented.
- destinationCSR  in  12  write address from Writeback; destinationCSR_ enum values equal the 12-bit CSR addresses.
- csrDestinationEnable  in  1  write csrWriteData to destinationCSR this cycle.
- csrWriteData  in  32  final write value; set/clear is already resolved upstream.
- dualValid  in  1  one instruction retires this cycle; increments minstret.
- trapRequest  in  1  take a trap this cycle.
- trapCause  in  32  mcause value; bit 31 set for interrupts.
- trapPC  in  32  PC saved into mepc; bits [1:0] are forced to 0.
- trapValue  in  32  saved into mtval.
- mretRequest  in  1  execute mret this cycle.
- interrupt  in  1  external interrupt line; sampled level.
- trapVector  out  32  mtvec with bits [1:0] forced to 0.
- returnAddress  out  32  current mepc.
- interruptPending  out  1  interrupt && mstatus.MIE && mie.MEIE; combinational.

## Operation

- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads as 11. All other bits read 0.
  - misa 0x301: read-only, 32'h4000_0100.
  - mie 0x304: only MEIE[11] is writable.
  - mtvec 0x305: bits [1:0] are hardwired to 0 (direct mode only).
  - mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits [1:0] are hardwired to 0.
  - mcause 0x342: full 32-bit read/write.
  - mtval 0x343: full 32-bit read/write.
  - mip 0x344: read-only. MEIP[11] reflects interrupt; all other bits read 0.
  - mcycle 0xB00 / mcycleh 0xB80: read/write.
  - minstret 0xB02 / minstreth 0xB82: read/write.
  - mhartid 0xF14: read-only, returns HART_ID.
- Any other address: readIllegal=1, readData=0.
- Writes to unimplemented or read-only addresses are silently dropped.
- Reset values:
  - mstatus MIE=0, MPIE=0.
  - mie=0, mscratch=0, mepc=0, mcause=0, mtval=0.
  - mtvec=MTVEC_RESET.
  - mcycle=0, minstret=0.
- mcycle increments by 1 every cycle while reset is low.
- minstret increments by 1 on every cycle with dualValid=1.
- Counter increments carry from the low word into the high word (64-bit wrap 0xFFFF_FFFF_FFFF_FFFF -> 0).
- Trap entry (trapRequest=1), applied at the clock edge:
  - mepc<=trapPC&~3, mcause<=trapCause, mtval<=trapValue.
  - MPIE<=MIE, MIE<=0.
- mret (mretRequest=1, trapRequest=0):
  - MIE<=MPIE, MPIE<=1.
- Priority when events coincide:
  - trapRequest > mretRequest > csrDestinationEnable for the mstatus, mepc, mcause and mtval fields.
  - A CSR write in the same cycle as trapRequest is dropped entirely.
  - The pipeline guarantees dualValid=0 when trapRequest=1.
- Software write versus increment in the same cycle:
  - The written word takes csrWriteData.
  - The other half of that counter holds its value that cycle (no increment, no carry).
  - The other counter still increments normally.

## Timing

- Reads are purely combinational and have no write bypass. A read of the address being written in the same cycle returns the old value; the new value is visible the next cycle.
- Writes, trap entry and mret all take effect at the next rising edge. trapVector and returnAddress reflect the update one cycle later.
- interruptPending follows interrupt combinationally. It drops in the cycle after trap entry because MIE is cleared.
- Asserting reset at any time immediately forces all registers to their reset values. Any in-flight trap or write in that cycle is lost.
- The first mcycle increment happens at the first rising edge after reset deasserts.

## Test plan

- Reset, then idle 10 cycles -> mcycle=10, minstret=0, mtvec reads 0x100, mstatus reads 0x0000_1800.
- Write mtvec=0x8000_0007 -> next cycle reads 0x8000_0004. Write to mhartid is dropped, and a read of 0x7C0 gives readIllegal=1, readData=0.
- Set MIE and MEIE, raise interrupt -> interruptPending=1. Then trapRequest with trapCause=0x8000_000B and trapPC=0x1236 -> mepc=0x1234, mcause=0x8000_000B, MIE=0, MPIE=1, interruptPending=0.
- mretRequest after the trap -> MIE=1, MPIE=1, returnAddress=0x1234.
- Write minstret=0xFFFF_FFFF, then retire one instruction -> minstret=0, minstreth=1. A write of mcycle=5 in the same cycle as an increment -> reads 5 the next cycle and mcycleh is unchanged.
- Same-cycle trapRequest and a CSR write of mepc=0xAAAA_AAA8 -> mepc holds the trapPC value. Asserting reset mid-test -> all CSRs return to their reset values.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR file bus: Execute read port, Writeback write port,
// trap/mret controls and the trap-state outputs to the pipeline.
//   master: pipeline side   slave: csr_file side
interface csr_file_if;
   logic [11:0] readAddress;
   logic [31:0] readData;
   logic        readIllegal;
   logic [11:0] destinationCSR;
   logic        csrDestinationEnable;
   logic [31:0] csrWriteData;
   logic        dualValid;
   logic        trapRequest;
   logic [31:0] trapCause;
   logic [31:0] trapPC;
   logic [31:0] trapValue;
   logic        mretRequest;
   logic        interrupt;
   logic [31:0] trapVector;
   logic [31:0] returnAddress;
   logic        interruptPending;

   modport master (
      output readAddress, destinationCSR,
      output csrDestinationEnable, csrWriteData,
      output dualValid, trapRequest, trapCause,
      output trapPC, trapValue, mretRequest,
      output interrupt,
      input  readData, readIllegal, trapVector,
      input  returnAddress, interruptPending
   );

   modport slave (
      input  readAddress, destinationCSR,
      input  csrDestinationEnable, csrWriteData,
      input  dualValid, trapRequest, trapCause,
      input  trapPC, trapValue, mretRequest,
      input  interrupt,
      output readData, readIllegal, trapVector,
      output returnAddress, interruptPending
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, mcycle/minstret, trap/mret
// sequencing. Ports: clock, reset (async high), bus (csr_file_if.slave).
module csr_file #(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input logic       clock,
   input logic       reset,
   csr_file_if.slave bus
);

   typedef enum logic [11:0] {
      CSR_MSTATUS   = 12'h300,
      CSR_MISA      = 12'h301,
      CSR_MIE       = 12'h304,
      CSR_MTVEC     = 12'h305,
      CSR_MSCRATCH  = 12'h340,
      CSR_MEPC      = 12'h341,
      CSR_MCAUSE    = 12'h342,
      CSR_MTVAL     = 12'h343,
      CSR_MIP       = 12'h344,
      CSR_MCYCLE    = 12'hB00,
      CSR_MINSTRET  = 12'hB02,
      CSR_MCYCLEH   = 12'hB80,
      CSR_MINSTRETH = 12'hB82,
      CSR_MHARTID   = 12'hF14
   } destinationCSR_e;

   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        meie_q, meie_d;
   logic [31:2] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:2] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic        we;

   // a write colliding with trap entry is discarded as a whole
   assign we = bus.csrDestinationEnable & ~bus.trapRequest;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, bus.dualValid};

      if (bus.trapRequest) begin
         mepc_d   = bus.trapPC[31:2];
         mcause_d = bus.trapCause;
         mtval_d  = bus.trapValue;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (bus.mretRequest) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (we) begin
         case (bus.destinationCSR)
            CSR_MSTATUS: begin
               mie_d  = bus.csrWriteData[3];
               mpie_d = bus.csrWriteData[7];
            end
            CSR_MEPC:   mepc_d   = bus.csrWriteData[31:2];
            CSR_MCAUSE: mcause_d = bus.csrWriteData;
            CSR_MTVAL:  mtval_d  = bus.csrWriteData;
            default: ;
         endcase
      end

      // a written counter half takes the data; the other half holds
      if (we) begin
         case (bus.destinationCSR)
            CSR_MIE:      meie_d     = bus.csrWriteData[11];
            CSR_MTVEC:    mtvec_d    = bus.csrWriteData[31:2];
            CSR_MSCRATCH: mscratch_d = bus.csrWriteData;
            CSR_MCYCLE:
               mcycle_d = {mcycle_q[63:32], bus.csrWriteData};
            CSR_MCYCLEH:
               mcycle_d = {bus.csrWriteData, mcycle_q[31:0]};
            CSR_MINSTRET:
               minstret_d = {minstret_q[63:32], bus.csrWriteData};
            CSR_MINSTRETH:
               minstret_d = {bus.csrWriteData, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET[31:2];
         mscratch_q <= 32'd0;
         mepc_q     <= 30'd0;
         mcause_q   <= 32'd0;
         mtval_q    <= 32'd0;
         mcycle_q   <= 64'd0;
         minstret_q <= 64'd0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         meie_q     <= meie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   always_comb begin
      bus.readData    = 32'd0;
      bus.readIllegal = 1'b0;
      case (bus.readAddress)
         CSR_MSTATUS:
            bus.readData = {19'd0, 2'b11, 3'd0, mpie_q,
                            3'd0, mie_q, 3'd0};
         CSR_MISA:      bus.readData = 32'h4000_0100;
         CSR_MIE:       bus.readData = {20'd0, meie_q, 11'd0};
         CSR_MTVEC:     bus.readData = {mtvec_q, 2'b00};
         CSR_MSCRATCH:  bus.readData = mscratch_q;
         CSR_MEPC:      bus.readData = {mepc_q, 2'b00};
         CSR_MCAUSE:    bus.readData = mcause_q;
         CSR_MTVAL:     bus.readData = mtval_q;
         CSR_MIP:       bus.readData = {20'd0, bus.interrupt, 11'd0};
         CSR_MCYCLE:    bus.readData = mcycle_q[31:0];
         CSR_MCYCLEH:   bus.readData = mcycle_q[63:32];
         CSR_MINSTRET:  bus.readData = minstret_q[31:0];
         CSR_MINSTRETH: bus.readData = minstret_q[63:32];
         CSR_MHARTID:   bus.readData = HART_ID;
         default:       bus.readIllegal = 1'b1;
      endcase
   end

   assign bus.trapVector       = {mtvec_q, 2'b00};
   assign bus.returnAddress    = {mepc_q, 2'b00};
   assign bus.interruptPending = bus.interrupt & mie_q & meie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed steps plus a randomized
// phase compared against a behavioural CSR model.
module tb_csr_file;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total  = 0;

   csr_file_if bus ();

   csr_file #(
      .HART_ID     (32'd0),
      .MTVEC_RESET (32'h0000_0100)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #50 clock = ~clock;

   // behavioural model state
   bit          m_mie, m_mpie, m_meie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   longint unsigned m_cyc, m_ins;

   logic [11:0] addrs [16] = '{
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
      12'hB82, 12'hF14, 12'h7C0, 12'h000};

   task automatic m_reset();
      m_mie = 0; m_mpie = 0; m_meie = 0;
      m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
   endtask

   function automatic logic [32:0] m_read(logic [11:0] a, logic irq);
      logic [31:0] d;
      logic        il;
      d = 0; il = 0;
      case (a)
         12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h301: d = 32'h4000_0100;
         12'h304: d = 32'(m_meie) << 11;
         12'h305: d = m_mtvec;
         12'h340: d = m_mscratch;
         12'h341: d = m_mepc;
         12'h342: d = m_mcause;
         12'h343: d = m_mtval;
         12'h344: d = 32'(irq) << 11;
         12'hB00: d = m_cyc[31:0];
         12'hB80: d = m_cyc[63:32];
         12'hB02: d = m_ins[31:0];
         12'hB82: d = m_ins[63:32];
         12'hF14: d = 32'd0;
         default: il = 1;
      endcase
      return {il, d};
   endfunction

   // one clock edge worth of architectural behaviour
   task automatic m_step();
      longint unsigned nc, ni;
      bit we;
      logic [31:0] wd;
      if (reset) begin
         m_reset();
         return;
      end
      nc = m_cyc + 1;
      ni = m_ins + (bus.dualValid ? 1 : 0);
      we = bus.csrDestinationEnable && !bus.trapRequest;
      wd = bus.csrWriteData;
      if (bus.trapRequest) begin
         m_mepc = bus.trapPC & ~32'd3;
         m_mcause = bus.trapCause;
         m_mtval = bus.trapValue;
         m_mpie = m_mie;
         m_mie = 0;
      end else if (bus.mretRequest) begin
         m_mie = m_mpie;
         m_mpie = 1;
      end else if (we) begin
         case (bus.destinationCSR)
            12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
            12'h341: m_mepc = wd & ~32'd3;
            12'h342: m_mcause = wd;
            12'h343: m_mtval = wd;
            default: ;
         endcase
      end
      if (we) begin
         case (bus.destinationCSR)
            12'h304: m_meie = wd[11];
            12'h305: m_mtvec = wd & ~32'd3;
            12'h340: m_mscratch = wd;
            12'hB00: nc = (m_cyc & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
            12'hB80: nc = (m_cyc & 64'hFFFF_FFFF) | (64'(wd) << 32);
            12'hB02: ni = (m_ins & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
            12'hB82: ni = (m_ins & 64'hFFFF_FFFF) | (64'(wd) << 32);
            default: ;
         endcase
      end
      m_cyc = nc;
      m_ins = ni;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.destinationCSR = 0; bus.csrDestinationEnable = 0;
      bus.csrWriteData = 0; bus.dualValid = 0;
      bus.trapRequest = 0; bus.trapCause = 0; bus.trapPC = 0;
      bus.trapValue = 0; bus.mretRequest = 0;
   endtask

   task automatic cyc();
      @(posedge clock);
      m_step();
      #1;
   endtask

   task automatic rchk(input string tag, input logic [11:0] a,
                       input logic [31:0] exp);
      bus.readAddress = a;
      #1;
      chk(tag, bus.readData, exp);
   endtask

   task automatic mchk(input string tag, input logic [11:0] a);
      logic [32:0] m;
      bus.readAddress = a;
      #1;
      m = m_read(a, bus.interrupt);
      chk({tag, "_data"}, bus.readData, m[31:0]);
      chk({tag, "_ill"}, {31'd0, bus.readIllegal}, {31'd0, m[32]});
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.csrDestinationEnable = 1;
      bus.destinationCSR = a;
      bus.csrWriteData = d;
      cyc();
      bus.csrDestinationEnable = 0;
   endtask

   initial begin
      logic [32:0] m;
      idle();
      bus.interrupt = 0;
      bus.readAddress = 0;
      m_reset();
      repeat (3) cyc();
      @(negedge clock);
      reset = 0;
      repeat (10) cyc();
      rchk("mcycle_10", 12'hB00, 32'd10);
      rchk("mcycleh_0", 12'hB80, 32'd0);
      rchk("minstret_0", 12'hB02, 32'd0);
      rchk("mtvec_rst", 12'h305, 32'h100);
      rchk("mstatus_rst", 12'h300, 32'h1800);
      rchk("mie_rst", 12'h304, 32'h0);
      chk("tvec_out_rst", bus.trapVector, 32'h100);
      chk("ra_rst", bus.returnAddress, 32'h0);
      chk("pend_rst", {31'd0, bus.interruptPending}, 32'd0);

      bus.csrDestinationEnable = 1;
      bus.destinationCSR = 12'h305;
      bus.csrWriteData = 32'h8000_0007;
      rchk("mtvec_nobypass", 12'h305, 32'h100);
      cyc();
      bus.csrDestinationEnable = 0;
      rchk("mtvec_wr", 12'h305, 32'h8000_0004);
      chk("tvec_out_wr", bus.trapVector, 32'h8000_0004);
      wr(12'hF14, 32'h1234_5678);
      rchk("mhartid_ro", 12'hF14, 32'h0);
      rchk("misa", 12'h301, 32'h4000_0100);
      rchk("illegal_data", 12'h7C0, 32'h0);
      chk("illegal_flag", {31'd0, bus.readIllegal}, 32'd1);

      wr(12'h300, 32'h0000_0008);
      wr(12'h304, 32'h0000_0800);
      bus.interrupt = 1;
      #1;
      chk("pend_on", {31'd0, bus.interruptPending}, 32'd1);
      rchk("mip_meip", 12'h344, 32'h800);
      bus.trapRequest = 1;
      bus.trapCause = 32'h8000_000B;
      bus.trapPC = 32'h1236;
      bus.trapValue = 32'hDEAD_0001;
      cyc();
      idle();
      rchk("trap_mepc", 12'h341, 32'h1234);
      rchk("trap_mcause", 12'h342, 32'h8000_000B);
      rchk("trap_mtval", 12'h343, 32'hDEAD_0001);
      rchk("trap_mstatus", 12'h300, 32'h1880);
      chk("trap_pend", {31'd0, bus.interruptPending}, 32'd0);
      chk("trap_ra", bus.returnAddress, 32'h1234);

      bus.mretRequest = 1;
      cyc();
      idle();
      rchk("mret_mstatus", 12'h300, 32'h1888);
      chk("mret_ra", bus.returnAddress, 32'h1234);
      chk("mret_pend", {31'd0, bus.interruptPending}, 32'd1);
      bus.interrupt = 0;

      wr(12'hB02, 32'hFFFF_FFFF);
      bus.dualValid = 1;
      cyc();
      bus.dualValid = 0;
      rchk("minstret_wrap", 12'hB02, 32'h0);
      rchk("minstreth_carry", 12'hB82, 32'h1);
      wr(12'hB00, 32'd5);
      rchk("mcycle_wr", 12'hB00, 32'd5);
      rchk("mcycleh_hold", 12'hB80, 32'd0);
      cyc();
      rchk("mcycle_inc", 12'hB00, 32'd6);

      bus.trapRequest = 1;
      bus.trapPC = 32'h2000_0002;
      bus.trapCause = 32'd2;
      bus.csrDestinationEnable = 1;
      bus.destinationCSR = 12'h341;
      bus.csrWriteData = 32'hAAAA_AAA8;
      cyc();
      idle();
      rchk("trap_vs_wr_mepc", 12'h341, 32'h2000_0000);
      bus.trapRequest = 1;
      bus.csrDestinationEnable = 1;
      bus.destinationCSR = 12'h340;
      bus.csrWriteData = 32'h55;
      cyc();
      idle();
      rchk("trap_drop_wr", 12'h340, 32'h0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         case ($urandom_range(3))
            0: d = 32'hFFFF_FFFF;
            1: d = 32'hFFFF_FFFE;
            default: d = $urandom;
         endcase
         bus.destinationCSR = addrs[$urandom_range(15)];
         bus.csrDestinationEnable = $urandom_range(1) == 1;
         bus.csrWriteData = d;
         bus.trapRequest = $urandom_range(15) == 0;
         bus.mretRequest = $urandom_range(15) == 0;
         bus.dualValid = !bus.trapRequest && $urandom_range(1) == 1;
         bus.trapCause = $urandom;
         bus.trapPC = $urandom;
         bus.trapValue = $urandom;
         bus.interrupt = $urandom_range(1) == 1;
         bus.readAddress = addrs[$urandom_range(15)];
         cyc();
         m = m_read(bus.readAddress, bus.interrupt);
         chk($sformatf("rnd%0d_data", i), bus.readData, m[31:0]);
         chk($sformatf("rnd%0d_ill", i),
             {31'd0, bus.readIllegal}, {31'd0, m[32]});
         chk($sformatf("rnd%0d_tvec", i), bus.trapVector, m_mtvec);
         chk($sformatf("rnd%0d_ra", i), bus.returnAddress, m_mepc);
         chk($sformatf("rnd%0d_pend", i),
             {31'd0, bus.interruptPending},
             {31'd0, bus.interrupt & m_mie & m_meie});
      end
      idle();
      mchk("post_rnd_mcycleh", 12'hB80);
      mchk("post_rnd_minstreth", 12'hB82);

      bus.interrupt = 0;
      reset = 1;
      m_reset();
      rchk("arst_mstatus", 12'h300, 32'h1800);
      rchk("arst_mtvec", 12'h305, 32'h100);
      rchk("arst_mcycle", 12'hB00, 32'h0);
      rchk("arst_mscratch", 12'h340, 32'h0);
      bus.trapRequest = 1;
      bus.trapPC = 32'h4444;
      bus.csrDestinationEnable = 1;
      bus.destinationCSR = 12'h340;
      bus.csrWriteData = 32'h77;
      cyc();
      idle();
      rchk("rst_mepc", 12'h341, 32'h0);
      rchk("rst_mcause", 12'h342, 32'h0);
      rchk("rst_mie", 12'h304, 32'h0);
      rchk("rst_minstreth", 12'hB82, 32'h0);
      @(negedge clock);
      reset = 0;
      cyc();
      rchk("first_inc", 12'hB00, 32'd1);
      mchk("model_mstatus", 12'h300);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
